// File: rtl/serial_pkg.sv
// Shared serial-link definitions: framing FSM state encodings and the default
// line level, used by the transmit serializer and the receive-side framing logic.
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } serial_state_e;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage : serial_pkg

// File: rtl/piso.sv
// Parallel-in/serial-out transmitter for the stepper-driver serial link: takes a
// word over valid/ready and shifts it out LSB-first, one bit per en_in strobe.
module piso
    import serial_pkg::*;
#(
    parameter int unsigned SIZE       = 8,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [SIZE-1:0] data_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            en_in,
    output logic            data_out,
    output logic            busy_out,
    output logic            done_out
);

    localparam int unsigned   CW       = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

    serial_state_e   state_q, state_d;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            data_q,  data_d;
    logic            ready_q, ready_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [SIZE-1:0] shifted_s;

    assign shifted_s = shreg_q >> 1;

    // State and output registers; reset aborts any word in flight without a done pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; data_d always carries the bit for the coming bit period.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                data_d  = IDLE_LEVEL;
                if (valid_in) begin
                    shreg_d = data_in;
                    data_d  = data_in[0];
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (en_in) begin
                    if (cnt_q == LAST_BIT) begin
                        data_d  = IDLE_LEVEL;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = shifted_s;
                        data_d  = shifted_s[0];
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign data_out  = data_q;
    assign ready_out = ready_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

endmodule : piso

// File: tb/tb_piso.sv
// Directed bench for piso: table of words with strobe spacing, plus hand-written
// sequences for back-to-back valid, mid-word reset and the single-bit variant.
module tb_piso;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din8;
    logic       v8, en8;
    logic       rdy8, dout8, busy8, done8;
    logic [0:0] din1;
    logic       v1, en1;
    logic       rdy1, dout1, busy1, done1;

    piso #(.SIZE(8), .IDLE_LEVEL(1'b0)) dut8 (
        .clk_in(clk), .rst_in(rst), .data_in(din8), .valid_in(v8), .ready_out(rdy8),
        .en_in(en8), .data_out(dout8), .busy_out(busy8), .done_out(done8)
    );

    piso #(.SIZE(1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk_in(clk), .rst_in(rst), .data_in(din1), .valid_in(v1), .ready_out(rdy1),
        .en_in(en1), .data_out(dout1), .busy_out(busy1), .done_out(done1)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] rx;   // model of the receive-side sipo sharing clk and en

    typedef struct {
        logic [7:0] word;
        logic [7:0] seq;     // seq[k] = k-th bit expected on the line
        int         gap;     // cycles per bit period
        logic       en_acc;  // strobe asserted in the accept cycle
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept8(input logic [7:0] w, input logic en_acc, input logic keep_valid,
                           input logic exp_b0);
        din8 = w; v8 = 1'b1; en8 = en_acc;
        step();
        v8 = keep_valid; en8 = 1'b0;
        rx = 8'h00;
        chk("acc_busy", busy8, 1);
        chk("acc_ready", rdy8, 0);
        chk("acc_bit0", dout8, exp_b0);
    endtask

    // Drives nstr strobes spaced gap cycles apart and checks every cycle.
    task automatic run_bits(input logic [7:0] seq, input int gap, input int nstr);
        for (int k = 0; k < nstr; k++) begin
            for (int g = 1; g < gap; g++) begin
                en8 = 1'b0;
                step();
                chk("hold_bit", dout8, seq[k]);
                chk("hold_busy", busy8, 1);
                chk("hold_ready", rdy8, 0);
            end
            en8 = 1'b1;
            rx = {dout8, rx[7:1]};
            step();
            en8 = 1'b0;
            if (k < 7) begin
                chk("next_bit", dout8, seq[k+1]);
                chk("mid_done", done8, 0);
                chk("mid_busy", busy8, 1);
            end else begin
                chk("end_done", done8, 1);
                chk("end_busy", busy8, 0);
                chk("end_ready", rdy8, 1);
                chk("end_idle", dout8, 0);
                chk("loopback", rx, seq);
            end
        end
        if (nstr == 8) begin
            step();
            chk("done_once", done8, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{word: 8'hA5, seq: 8'b1010_0101, gap: 4, en_acc: 1'b0};
        vecs[1] = '{word: 8'h3C, seq: 8'b0011_1100, gap: 2, en_acc: 1'b0};
        vecs[2] = '{word: 8'h81, seq: 8'b1000_0001, gap: 3, en_acc: 1'b1};
        vecs[3] = '{word: 8'h6E, seq: 8'b0110_1110, gap: 1, en_acc: 1'b0};
        vecs[4] = '{word: 8'h00, seq: 8'b0000_0000, gap: 1, en_acc: 1'b1};

        rst = 1'b1; din8 = 8'h00; v8 = 1'b0; en8 = 1'b0;
        din1 = 1'b0; v1 = 1'b0; en1 = 1'b1; rx = 8'h00;
        step(); step();
        rst = 1'b0;
        chk("rst_ready", rdy8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_dout", dout8, 0);
        chk("rst_dout1", dout1, 1);
        chk("rst_ready1", rdy1, 1);
        step();
        chk("idle_ignores_en", busy8, 0);

        for (int i = 0; i < 5; i++) begin
            accept8(vecs[i].word, vecs[i].en_acc, 1'b0, vecs[i].seq[0]);
            run_bits(vecs[i].seq, vecs[i].gap, 8);
        end

        // valid held high: FF, then 01 presented while busy
        accept8(8'hFF, 1'b0, 1'b1, 1'b1);
        din8 = 8'h01;
        run_bits(8'hFF, 2, 8);
        chk("b2b_second_acc", busy8, 1);
        chk("b2b_bit0", dout8, 1);
        chk("b2b_ready", rdy8, 0);
        v8 = 1'b0; rx = 8'h00;
        run_bits(8'h01, 2, 8);

        // reset after 3 strobes of F0
        accept8(8'hF0, 1'b0, 1'b0, 1'b0);
        run_bits(8'hF0, 2, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_dout", dout8, 0);
        chk("mrst_busy", busy8, 0);
        chk("mrst_ready", rdy8, 1);
        chk("mrst_done", done8, 0);
        rst = 1'b1; v8 = 1'b1; din8 = 8'h77;
        step();
        rst = 1'b0; v8 = 1'b0;
        chk("rst_wins", busy8, 0);
        for (int g = 0; g < 3; g++) begin
            en8 = 1'b1;
            step();
            chk("post_rst_nodone", done8, 0);
            chk("post_rst_idle", busy8, 0);
        end
        en8 = 1'b0;
        accept8(8'h5A, 1'b0, 1'b0, 1'b0);
        run_bits(8'h5A, 2, 8);

        // SIZE=1, idle level 1, en tied high
        din1 = 1'b0; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("s1_bit", dout1, 0);
        chk("s1_busy", busy1, 1);
        chk("s1_done0", done1, 0);
        step();
        chk("s1_dout_end", dout1, 1);
        chk("s1_done", done1, 1);
        chk("s1_ready", rdy1, 1);
        step();
        chk("s1_done_once", done1, 0);
        chk("s1_idle", dout1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_piso

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in/serial-out transmitter: the transmit-side counterpart of the existing serial-to-parallel shift register used on the stepper driver's serial link.
- Accepts a SIZE-bit word via a valid/ready handshake.
- Shifts the word out LSB-first, one bit per `en_in` strobe, so the receive shift register recovers the word unchanged after SIZE strobes.
- Reports busy and end-of-word. The shift strobe comes from the existing clock-divider logic.

Parameters:
- SIZE, 8, word width in bits; legal range 1..32.
- IDLE_LEVEL, 1'b0, level driven on `data_out` when no word is in flight.

Ports:
- `clk_in`  input  1  system clock; all logic on rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `data_in`  input  SIZE  parallel word; sampled only on handshake.
- `valid_in`  input  1  `data_in` valid.
- `ready_out`  output  1  block can accept a word.
- `en_in`  input  1  shift strobe, one bit period per high cycle.
- `data_out`  output  1  serial bit stream, LSB first.
- `busy_out`  output  1  word in flight.
- `done_out`  output  1  one-cycle pulse after the last bit period ends.

Behaviour:
- Reset (rst_in=1 at posedge, highest priority):
  - state=IDLE, shift register=0, bit counter=0.
  - `data_out`=IDLE_LEVEL, `ready_out`=1, `busy_out`=0, `done_out`=0.
- State machine, two states: IDLE, SHIFT. All outputs are registered.
- IDLE:
  - `ready_out`=1, `busy_out`=0; `en_in` is ignored.
  - Accept happens when `valid_in`=1 at posedge. Next cycle:
    - shift register=`data_in`, `data_out`=`data_in`[0], counter=0;
    - `ready_out`=0, `busy_out`=1, state=SHIFT.
- SHIFT, on a cycle with `en_in`=1:
  - If counter < SIZE-1: shift register shifts right by one, `data_out`=next bit, counter+1.
  - If counter == SIZE-1: `data_out`=IDLE_LEVEL, `done_out`=1 for exactly one cycle, `busy_out`=0, `ready_out`=1, state=IDLE.
- SHIFT, on a cycle with `en_in`=0: all state holds.
- Bit timing:
  - Bit k is driven from the posedge after strobe k (bit 0: after accept) until the posedge of strobe k+1.
  - A receiver that samples on the same `en_in` strobe therefore captures bits 0..SIZE-1 in order.
- Throughput: at least one IDLE cycle between words; `ready_out` is never high in SHIFT.
- Latency: accept to `done_out` = SIZE strobes + 1 cycle.
- Counter width = max(1, clog2(SIZE)). The counter never exceeds SIZE-1 and never wraps.
- Boundary conditions:
  - `en_in`=1 in the accept cycle: ignored. Counting starts on the next strobe.
  - `valid_in` during SHIFT: ignored. No accept, no buffering, no error flag.
  - `data_in` changes after accept: no effect on the word in flight.
  - SIZE=1: accept, then the first strobe ends the word and pulses `done_out`.
  - `en_in` held high continuously: one bit per clock, word ends after SIZE cycles.
  - `rst_in` mid-word: abort immediately, all outputs take reset values, no `done_out`.
  - `rst_in` and `valid_in` together: reset wins, word not accepted.

Decomposition:
- Shared package/header `serial_pkg`: state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1, and the default idle level constant. These are also used by a later receive-side framing FSM.
- No sub-module: the shift register, counter and FSM stay in one module.

Test Plan:
- Reset, then `data_in`=8'hA5, `valid_in` pulse, `en_in` every 4th cycle.
  -> `data_out` sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  -> `done_out` high for exactly 1 cycle after the 8th strobe; `ready_out` returns to 1.
- Loopback: `data_out` into the existing sipo (SIZE=8, same `clk_in` and `en_in`), send 8'h3C.
  -> sipo output reads 8'h3C on the cycle `done_out` is high.
- `valid_in` held high with 8'hFF, then 8'h01 presented while busy.
  -> the word is 8'hFF only; 8'h01 is accepted only after `ready_out` rises, sent as a second word.
- `rst_in` asserted after 3 strobes of 8'hF0.
  -> next cycle `data_out`=IDLE_LEVEL, `busy_out`=0, `ready_out`=1, no `done_out`.
  -> a fresh word afterwards serialises correctly.
- SIZE=1, IDLE_LEVEL=1, send 1'b0 with `en_in` tied high.
  -> `data_out` 1→0 for one cycle then back to 1; `done_out` pulses once.
- `en_in`=1 in the accept cycle of 8'h81.
  -> bit 0 (=1) is still held until the next strobe; all 8 bits are emitted.
